// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the MIPS32 core.
//   OP_J / OP_LW / OP_SW : primary opcodes (instr[31:26])
//   NOP_WORD             : instruction-memory fill word, treated as a bubble
//   PC_W_DEF             : default PC width in words (1024-entry imem)
package cpu_pkg;

   localparam logic [5:0]  OP_J     = 6'b000010;
   localparam logic [5:0]  OP_LW    = 6'b100011;
   localparam logic [5:0]  OP_SW    = 6'b101011;
   localparam logic [31:0] NOP_WORD = 32'hFFFF_FFFF;

   localparam int unsigned PC_W_DEF = 10;

   function automatic logic is_jump(input logic [31:0] instr);
      return instr[31:26] == OP_J;
   endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: combinational next-PC selection and jump decode.
//   i_pc             : current PC (word address)
//   i_instr          : instruction word fetched at i_pc
//   i_stall          : hold the PC
//   i_redirect_valid : taken branch from execute
//   i_redirect_pc    : branch target (word address)
//   o_next_pc        : PC for the next cycle
//   o_pc_plus1       : i_pc + 1, modulo 2^PC_W
module fetch_next_pc
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W = PC_W_DEF
) (
   input  logic [PC_W-1:0] i_pc,
   input  logic [31:0]     i_instr,
   input  logic            i_stall,
   input  logic            i_redirect_valid,
   input  logic [PC_W-1:0] i_redirect_pc,
   output logic [PC_W-1:0] o_next_pc,
   output logic [PC_W-1:0] o_pc_plus1
);

   logic [PC_W-1:0] w_jump_tgt;
   logic            w_unused_tgt;

   assign o_pc_plus1 = i_pc + {{(PC_W-1){1'b0}}, 1'b1};
   assign w_jump_tgt = i_instr[PC_W-1:0];
   // Jump target bits above the PC width are deliberately dropped.
   assign w_unused_tgt = ^i_instr[25:PC_W];

   // Priority: redirect > stall > jump > sequential.
   always_comb begin
      o_next_pc = o_pc_plus1;
      if (i_redirect_valid) begin
         o_next_pc = i_redirect_pc;
      end else if (i_stall) begin
         o_next_pc = i_pc;
      end else if (is_jump(i_instr)) begin
         o_next_pc = w_jump_tgt;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC, IF/ID pipeline register and delivered-instruction
// counter. Jumps resolve here with no penalty; an execute redirect flushes IF/ID.
//   clk, reset_n        : clock, async active-low reset
//   imem_addr/imem_data : word address out, combinational instruction word in
//   stall               : hold PC, IF/ID and counter
//   redirect_valid/_pc  : taken branch and its target
//   ifid_*              : registered instruction, its PC, PC+1 and valid flag
//   fetch_count         : instructions delivered with ifid_valid=1 (wraps)
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W     = PC_W_DEF,
   parameter int unsigned RESET_PC = 0
) (
   input  logic            clk,
   input  logic            reset_n,
   output logic [31:0]     imem_addr,
   input  logic [31:0]     imem_data,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [31:0]     ifid_instr,
   output logic [PC_W-1:0] ifid_pc,
   output logic [PC_W-1:0] ifid_pc_plus1,
   output logic            ifid_valid,
   output logic [31:0]     fetch_count
);

   logic [PC_W-1:0] r_pc;
   logic [31:0]     r_instr;
   logic [PC_W-1:0] r_ifid_pc;
   logic [PC_W-1:0] r_ifid_pc_plus1;
   logic            r_valid;
   logic [31:0]     r_count;

   logic [PC_W-1:0] w_next_pc;
   logic [PC_W-1:0] w_pc_plus1;
   logic            w_load_ifid;
   logic            w_deliver;

   fetch_next_pc #(
      .PC_W (PC_W)
   ) u_next_pc (
      .i_pc             (r_pc),
      .i_instr          (imem_data),
      .i_stall          (stall),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .o_next_pc        (w_next_pc),
      .o_pc_plus1       (w_pc_plus1)
   );

   // Redirect overrides stall so the wrong-path word is squashed, not held.
   assign w_load_ifid = redirect_valid || !stall;
   assign w_deliver   = !redirect_valid && (imem_data != NOP_WORD);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc            <= PC_W'(RESET_PC);
         r_instr         <= NOP_WORD;
         r_ifid_pc       <= '0;
         r_ifid_pc_plus1 <= '0;
         r_valid         <= 1'b0;
         r_count         <= '0;
      end else begin
         r_pc <= w_next_pc;
         if (w_load_ifid) begin
            r_instr         <= imem_data;
            r_ifid_pc       <= r_pc;
            r_ifid_pc_plus1 <= w_pc_plus1;
            r_valid         <= w_deliver;
            if (w_deliver) begin
               r_count <= r_count + 32'd1;
            end
         end
      end
   end

   assign imem_addr     = {{(32-PC_W){1'b0}}, r_pc};
   assign ifid_instr    = r_instr;
   assign ifid_pc       = r_ifid_pc;
   assign ifid_pc_plus1 = r_ifid_pc_plus1;
   assign ifid_valid    = r_valid;
   assign fetch_count   = r_count;

endmodule
